// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes, branch-resolve selects and operand selects.
// Imported by the issue stage, its decoder and the ALU itself.
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLL = 4'd2,
        ALU_XOR = 4'd3,
        ALU_SRL = 4'd4,
        ALU_SRA = 4'd5,
        ALU_OR  = 4'd6,
        ALU_AND = 4'd7,
        ALU_BLT = 4'd8,
        ALU_BGE = 4'd9
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] BR_NONE  = 2'd0;
    localparam logic [1:0] BR_ZERO  = 2'd1;
    localparam logic [1:0] BR_NZERO = 2'd2;
    localparam logic [1:0] BR_FLAG  = 2'd3;

    typedef enum logic [1:0] {
        OP1_RS1,
        OP1_PC,
        OP1_ZERO
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2,
        OP2_IMM,
        OP2_FOUR,
        OP2_ZERO
    } op2_sel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// EX-side bus between the issue register and the ALU: control code, operands, branch select.
// The issue stage drives it through the master modport, the ALU consumes it through slave.
interface alu_issue_stage_if #(
    parameter int XLEN   = alu_pkg::XLEN,
    parameter int CTRL_W = alu_pkg::CTRL_W
);
    logic              valid_o;
    logic              ready_i;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [XLEN-1:0]   data1_o;
    logic [XLEN-1:0]   data2_o;
    logic [1:0]        br_sel_o;
    logic              illegal_o;

    modport master (
        output valid_o, alu_ctrl_o, data1_o, data2_o, br_sel_o, illegal_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, alu_ctrl_o, data1_o, data2_o, br_sel_o, illegal_o,
        output ready_i
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decoder: opcode/funct fields -> ALU control, operand selects, br_sel, illegal.
import alu_pkg::*;

module alu_op_decode (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_ctrl_e  ctrl_o,
    output op1_sel_e   op1_sel_o,
    output op2_sel_e   op2_sel_o,
    output logic       shift_o,
    output logic [1:0] br_sel_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = ALU_ADD;
        op1_sel_o = OP1_ZERO;
        op2_sel_o = OP2_ZERO;
        shift_o   = 1'b0;
        br_sel_o  = BR_NONE;
        illegal_o = 1'b0;

        case (opcode_i)
            OPC_OP, OPC_OP_IMM: begin
                op1_sel_o = OP1_RS1;
                op2_sel_o = (opcode_i == OPC_OP) ? OP2_RS2 : OP2_IMM;
                // funct7b5 only selects SUB for register adds; ADDI bit 30 is immediate data
                case (funct3_i)
                    3'b000: ctrl_o = (opcode_i == OPC_OP && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        ctrl_o  = ALU_SLL;
                        shift_o = 1'b1;
                    end
                    3'b100: ctrl_o = ALU_XOR;
                    3'b101: begin
                        ctrl_o  = funct7b5_i ? ALU_SRA : ALU_SRL;
                        shift_o = 1'b1;
                    end
                    3'b110: ctrl_o = ALU_OR;
                    3'b111: ctrl_o = ALU_AND;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                op1_sel_o = OP1_RS1;
                op2_sel_o = OP2_IMM;
            end
            OPC_LUI: begin
                op1_sel_o = OP1_ZERO;
                op2_sel_o = OP2_IMM;
            end
            OPC_AUIPC: begin
                op1_sel_o = OP1_PC;
                op2_sel_o = OP2_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                op1_sel_o = OP1_PC;
                op2_sel_o = OP2_FOUR;
            end
            OPC_BRANCH: begin
                op1_sel_o = OP1_RS1;
                op2_sel_o = OP2_RS2;
                case (funct3_i)
                    3'b000: begin
                        ctrl_o   = ALU_SUB;
                        br_sel_o = BR_ZERO;
                    end
                    3'b001: begin
                        ctrl_o   = ALU_SUB;
                        br_sel_o = BR_NZERO;
                    end
                    3'b100: begin
                        ctrl_o   = ALU_BLT;
                        br_sel_o = BR_FLAG;
                    end
                    3'b101: begin
                        ctrl_o   = ALU_BGE;
                        br_sel_o = BR_FLAG;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase

        // Unsupported encodings issue as a harmless ADD of zeros
        if (illegal_o) begin
            ctrl_o    = ALU_ADD;
            op1_sel_o = OP1_ZERO;
            op2_sel_o = OP2_ZERO;
            shift_o   = 1'b0;
            br_sel_o  = BR_NONE;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes, selects ALU operands and holds them behind a valid/ready handshake.
// Optional ALU_ISSUE_PERF_CNT_EN adds issued/stall performance counters.
import alu_pkg::*;

module alu_issue_stage #(
    parameter int XLEN   = alu_pkg::XLEN,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
`ifdef ALU_ISSUE_PERF_CNT_EN
    output logic [31:0]      issued_cnt_o,
    output logic [31:0]      stall_cnt_o,
`endif
    alu_issue_stage_if.master ex_bus
);

    alu_ctrl_e        dec_ctrl;
    op1_sel_e         dec_op1_sel;
    op2_sel_e         dec_op2_sel;
    logic             dec_shift;
    logic [1:0]       dec_br_sel;
    logic             dec_illegal;

    logic [XLEN-1:0]  op1_val;
    logic [XLEN-1:0]  op2_raw;
    logic [XLEN-1:0]  op2_val;

    logic             valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]  data1_q, data1_d;
    logic [XLEN-1:0]  data2_q, data2_d;
    logic [1:0]       br_sel_q, br_sel_d;
    logic             illegal_q, illegal_d;

    logic             load;
    logic             transfer;

    alu_op_decode u_decode (
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .ctrl_o     (dec_ctrl),
        .op1_sel_o  (dec_op1_sel),
        .op2_sel_o  (dec_op2_sel),
        .shift_o    (dec_shift),
        .br_sel_o   (dec_br_sel),
        .illegal_o  (dec_illegal)
    );

    always_comb begin
        op1_val = '0;
        op2_raw = '0;
        case (dec_op1_sel)
            OP1_RS1: op1_val = rs1_data_i;
            OP1_PC:  op1_val = pc_i;
            default: op1_val = '0;
        endcase
        case (dec_op2_sel)
            OP2_RS2:  op2_raw = rs2_data_i;
            OP2_IMM:  op2_raw = imm_i;
            OP2_FOUR: op2_raw = XLEN'(4);
            default:  op2_raw = '0;
        endcase
        // The ALU shifts by all of data2, so only the 5-bit shift amount may reach it
        op2_val = dec_shift ? {{(XLEN-5){1'b0}}, op2_raw[4:0]} : op2_raw;
    end

    assign ready_o  = !valid_q || ex_bus.ready_i;
    assign load     = valid_i && ready_o && !flush_i;
    assign transfer = valid_q && ex_bus.ready_i;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        br_sel_d  = br_sel_q;
        illegal_d = illegal_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            ctrl_d    = CTRL_W'(dec_ctrl);
            data1_d   = op1_val;
            data2_d   = op2_val;
            br_sel_d  = dec_br_sel;
            illegal_d = dec_illegal;
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            br_sel_q  <= BR_NONE;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            br_sel_q  <= br_sel_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_bus.valid_o    = valid_q;
    assign ex_bus.alu_ctrl_o = ctrl_q;
    assign ex_bus.data1_o    = data1_q;
    assign ex_bus.data2_o    = data2_q;
    assign ex_bus.br_sel_o   = br_sel_q;
    assign ex_bus.illegal_o  = illegal_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] issued_cnt_q, issued_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Flush cycles are excluded from both counts
    always_comb begin
        issued_cnt_d = issued_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!flush_i) begin
            if (transfer)
                issued_cnt_d = issued_cnt_q + 32'd1;
            if (valid_q && !ex_bus.ready_i)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign issued_cnt_o = issued_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
